int_ctrl: RTL
=============

Name: int_ctrl

Overview:
Parametrised interrupt controller feeding the CPU core's active-low irq and nmi inputs.
- Merges SRC_N active-low peripheral interrupt lines (GPIO, SPI, timers) into one irq, with per-source mask and level/edge mode.
- Generates a periodic NMI pulse train (vblank-style) of programmable period and width.
- Sits in the system between peripherals and CPU; configured over the same byte-wide register bus as the other peripherals.

Parameters:
SRC_N, 4, number of interrupt sources (1..8)
DATA_N, 8, register bus width (at least SRC_N)
CNT_W, 16, NMI counter width
NMI_PERIOD, 16666, NMI period in clk cycles (2..2^CNT_W)
NMI_LEN, 20, NMI low-pulse width in clk cycles (1..NMI_PERIOD-1)

Ports:
clk  in  1  system clock, rising edge
n_reset  in  1  asynchronous active-low reset
src  in  SRC_N  active-low interrupt requests, asynchronous to clk
sel  in  1  register access strobe
we  in  1  1=write, 0=read (qualified by sel)
addr  in  2  register index
din  in  DATA_N  write data
dout  out  DATA_N  read data, combinational; 0 when sel=0
irq  out  1  active-low CPU interrupt request, registered
nmi  out  1  active-low CPU NMI, registered

Behaviour:
Reset and clocking
- One clock domain: clk.
- n_reset is asynchronous, active-low.
- Reset values:
  - irq=1, nmi=1
  - STATUS latches, MASK, MODE, CTRL = 0
  - Synchroniser flops = 1 (idle)
  - NMI counter = 0
- Reset mid-pulse forces nmi=1 immediately (asynchronous).

Register map (bits above SRC_N read 0, writes ignored)
- addr 0 STATUS
  - Read: pending[SRC_N-1:0].
  - Write: 1 clears edge-latched pending bits; 0 has no effect.
- addr 1 MASK: read/write; 1 = source enabled.
- addr 2 MODE: read/write; 1 = falling-edge latched, 0 = level (active while low).
- addr 3 CTRL
  - bit0 = nmi_en, read/write.
  - Other bits: see Optional Feature.

Source path
- Each src bit passes a 2-flop synchroniser (s1, s2), then s3 for edge detect.
- Edge mode:
  - Latch sets when s3=1 and s2=0.
  - Cleared by STATUS write-1.
  - Set and clear in the same cycle: set wins.
  - Writing MODE bit to 0 clears that bit's latch.
- Level mode: pending = ~s2; not latched; STATUS write has no effect.
- irq register = ~|(pending & MASK).
- Latency: src sampled low at edge E0 -> pending visible after E2 -> irq=0 after E3.
- Deassert latency (level source released, or latch cleared at edge C): irq=1 after C+1. A MASK write takes effect the same way.
- Pending is tracked regardless of MASK. Unmasking a pending source asserts irq one edge after the write.

NMI generator
- nmi_en=0: counter held at 0, nmi=1 at the next edge.
- nmi_en written 0->1 at edge W: counter=0 after W and counts each cycle, wrapping NMI_PERIOD-1 -> 0.
- nmi register = ~(nmi_en & (counter < NMI_LEN)).
- Result: nmi low after W+1 for exactly NMI_LEN cycles, then high; repeats every NMI_PERIOD cycles.
- Disabling mid-pulse truncates the pulse: nmi=1 after the following edge.
- Rewriting nmi_en=1 while already enabled does not restart the counter.

Optional Feature:
Macro: INT_CTRL_PRIO_EN
- Defined:
  - CTRL read bits[6:4] = index of the lowest-numbered source with (pending & MASK); bit7 = 1 when any such source exists.
  - A read of CTRL (sel=1, we=0, addr=3) clears that source's latch if it is in edge mode (read-acknowledge).
  - The ack and a new edge in the same cycle: set wins.
- Not defined: CTRL bits[7:1] read 0; CTRL reads have no side effects.

Test Plan:
1. Reset: hold n_reset=0 with src=0 and random bus traffic -> irq=1, nmi=1, all registers read 0; release -> still irq=1 because MASK=0.
2. Level mode: MASK=0x1, MODE=0, drive src[0]=0 at edge E0 -> irq=0 after E3; src[0]=1 -> irq=1 three edges later; STATUS reads 0x0.
3. Edge mode: MODE=0x2, MASK=0x2, pulse src[1] low for 1 cycle -> STATUS=0x2, irq=0 held; write STATUS=0x2 -> irq=1 after 2 edges; write-clear coincident with a new edge -> STATUS remains 0x2.
4. Mask: src[2] edge-latched with MASK=0 -> irq stays 1, STATUS=0x4; write MASK=0x4 -> irq=0 one edge later.
5. NMI (NMI_PERIOD=10, NMI_LEN=3): write CTRL=1 -> nmi low cycles 1..3, high 4..10, low again at 11; write CTRL=0 during the second pulse -> nmi=1 after the next edge.
6. INT_CTRL_PRIO_EN: sources 1 and 3 edge-pending, both masked -> CTRL reads 0x91 then 0xB1, STATUS then 0x0, irq=1; without the macro -> CTRL reads 0x01 and STATUS stays 0xA.

Source files
------------

// File: rtl/int_ctrl.sv
// int_ctrl: merges active-low peripheral interrupts into irq and drives a periodic nmi.
// Optional INT_CTRL_PRIO_EN adds a priority index and read-acknowledge on CTRL.
`timescale 1ns/1ps
module int_ctrl #(
    parameter int SRC_N      = 4,
    parameter int DATA_N     = 8,
    parameter int CNT_W      = 16,
    parameter int NMI_PERIOD = 16666,
    parameter int NMI_LEN    = 20
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic [SRC_N-1:0]  src,
    input  logic              sel,
    input  logic              we,
    input  logic [1:0]        addr,
    input  logic [DATA_N-1:0] din,
    output logic [DATA_N-1:0] dout,
    output logic              irq,
    output logic              nmi
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NMI_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_LEN  = CNT_W'(NMI_LEN);

    logic [SRC_N-1:0]  s1, s2, s3;
    logic [SRC_N-1:0]  latch, mask, mode;
    logic              nmi_en;
    logic [CNT_W-1:0]  cnt;

    logic [SRC_N-1:0]  wdata, pending, fall;
    logic [SRC_N-1:0]  ack, clr, mode_nxt;
    logic [DATA_N-1:0] ctrl_rd;
    logic              wr_status, wr_mask, wr_mode, wr_ctrl;
    logic              unused_din;

    assign wdata     = din[SRC_N-1:0];
    assign unused_din = ^din;

    assign wr_status = sel & we & (addr == 2'd0);
    assign wr_mask   = sel & we & (addr == 2'd1);
    assign wr_mode   = sel & we & (addr == 2'd2);
    assign wr_ctrl   = sel & we & (addr == 2'd3);

    // Falling edge seen one stage past the synchroniser.
    assign fall     = s3 & ~s2;
    assign pending  = latch | (~mode & ~s2);
    assign mode_nxt = wr_mode ? wdata : mode;
    assign clr      = (wr_status ? wdata : '0) | ack;

`ifdef INT_CTRL_PRIO_EN
    logic [SRC_N-1:0] active;
    logic [2:0]       prio_idx;
    logic             prio_any;
    logic             rd_ctrl;

    assign rd_ctrl  = sel & ~we & (addr == 2'd3);
    assign active   = pending & mask;
    assign prio_any = |active;

    always_comb begin
        prio_idx = '0;
        for (int i = SRC_N - 1; i >= 0; i--) begin
            if (active[i]) prio_idx = 3'(i);
        end
    end

    // Reading CTRL acknowledges the reported source if it is edge-latched.
    assign ack = (rd_ctrl && prio_any)
               ? ((SRC_N'(1) << prio_idx) & mode)
               : '0;
    assign ctrl_rd = DATA_N'({prio_any, prio_idx, 3'b000, nmi_en});
`else
    assign ack     = '0;
    assign ctrl_rd = DATA_N'(nmi_en);
`endif

    always_comb begin
        dout = '0;
        if (sel) begin
            unique case (addr)
                2'd0:    dout = DATA_N'(pending);
                2'd1:    dout = DATA_N'(mask);
                2'd2:    dout = DATA_N'(mode);
                default: dout = ctrl_rd;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            s1     <= '1;
            s2     <= '1;
            s3     <= '1;
            latch  <= '0;
            mask   <= '0;
            mode   <= '0;
            nmi_en <= 1'b0;
            cnt    <= '0;
            irq    <= 1'b1;
            nmi    <= 1'b1;
        end else begin
            s1 <= src;
            s2 <= s1;
            s3 <= s2;
            // A new edge beats a same-cycle clear; leaving edge mode drops the latch.
            latch <= ((latch & ~clr) | (fall & mode)) & mode_nxt;
            mode  <= mode_nxt;
            if (wr_mask) mask <= wdata;
            if (wr_ctrl) nmi_en <= din[0];
            irq <= ~|(pending & mask);
            nmi <= ~(nmi_en && (cnt < CNT_LEN));
            if (!nmi_en) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule
